// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and helpers for the PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Explicit state encodings, kept visible for debug and waveform reading
    localparam logic [1:0] c_ST_PLL_RST   = 2'd0;
    localparam logic [1:0] c_ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_ST_STABLE    = 2'd2;
    localparam logic [1:0] c_ST_RUN       = 2'd3;

    typedef enum logic [1:0] {
        PLL_RST   = c_ST_PLL_RST,
        WAIT_LOCK = c_ST_WAIT_LOCK,
        STABLE    = c_ST_STABLE,
        RUN       = c_ST_RUN
    } pll_seq_state_t;

    // Width of the shared counter: large enough to hold (largest cycle count - 1)
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Multi-stage single-bit synchroniser, async active-low reset
//               to 0. Depth is clamped to a minimum of two flops.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    localparam int c_STAGES = (STAGES < 2) ? 2 : STAGES;

    logic [c_STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[c_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Pulses the PLL reset, qualifies the synchronised lock and
//               releases system reset after lock has been stable. Re-cycles
//               the PLL on lock loss, lock timeout or soft reset request.
//               Runs on the free-running reference clock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  timeout_err,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int c_CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [c_CNT_W-1:0] c_PLL_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    pll_seq_state_t        r_state;
    pll_seq_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  r_pll_rst;
    logic                  r_run;
    logic                  r_timeout_err;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  w_pll_rst_nxt;
    logic                  w_run_nxt;
    logic                  w_timeout_nxt;
    logic [LOSS_CNT_W-1:0] w_loss_nxt;
    logic                  w_restart;
    logic                  w_timeout_hit;
    logic                  w_loss_hit;
    logic                  w_lock_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PLL_RST;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_run         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_loss_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pll_rst     <= w_pll_rst_nxt;
            r_run         <= w_run_nxt;
            r_timeout_err <= w_timeout_nxt;
            r_loss_cnt    <= w_loss_nxt;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the transition
    always_comb begin
        w_state_nxt   = r_state;
        w_restart     = 1'b0;
        w_timeout_hit = 1'b0;
        w_loss_hit    = 1'b0;

        if (soft_rst_req) begin
            // Soft request wins over everything, and restarts the pulse even
            // when already in PLL_RST
            w_state_nxt = PLL_RST;
            w_restart   = 1'b1;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == c_PLL_RST_LAST) w_state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = STABLE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        w_state_nxt   = PLL_RST;
                        w_timeout_hit = 1'b1;
                    end
                end
                STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = WAIT_LOCK;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = PLL_RST;
                        w_loss_hit  = 1'b1;
                    end
                end
                default: w_state_nxt = PLL_RST;
            endcase
        end

        w_cnt_nxt     = (w_restart || (w_state_nxt != r_state)) ? '0 : r_cnt + c_CNT_W'(1);
        w_pll_rst_nxt = (w_state_nxt == PLL_RST);
        w_run_nxt     = (w_state_nxt == RUN);
        w_timeout_nxt = r_timeout_err | w_timeout_hit;

        w_loss_nxt = r_loss_cnt;
        if (w_loss_hit && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            w_loss_nxt = r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst_n     = r_run;
    assign ready         = r_run;
    assign timeout_err   = r_timeout_err;
    assign lock_loss_cnt = r_loss_cnt;

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the 50 MHz-in / 200 MHz + 10 MHz-out PLL wrapper, which has `rst`, `outclk_0`, `outclk_1` and `locked` ports.
- Drives the PLL reset, qualifies the asynchronous `locked` signal, and releases a single system reset only after lock has been continuously stable.
- Runs on the free-running reference clock, never on a PLL output. On loss of lock it re-asserts system reset, counts the event and re-cycles the PLL.
- Lock-acquisition timeouts are flagged and retried automatically.

Parameters:
- SYNC_STAGES, 2, flops in the `pll_locked` synchroniser (minimum 2).
- PLL_RST_CYCLES, 16, clk cycles `pll_rst` is held high per PLL reset pulse.
- LOCK_STABLE_CYCLES, 1024, consecutive cycles synchronised lock must stay high before system reset is released.
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before timeout.
- LOSS_CNT_W, 8, width of the lock-loss event counter.

Ports:
- clk  in  1  free-running 50 MHz reference clock (same net as the PLL refclk).
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL `locked`, asynchronous to clk.
- soft_rst_req  in  1  single-cycle pulse forcing a full PLL re-cycle.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low system reset for downstream logic.
- ready  out  1  high while in RUN.
- timeout_err  out  1  sticky; set on any lock-acquisition timeout.
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of lock losses seen in RUN.

Behaviour:
- Reset values, applied asynchronously on `rst_n` low:
  - state = PLL_RST; internal counter = 0; synchroniser flops = 0.
  - pll_rst = 1; sys_rst_n = 0; ready = 0; timeout_err = 0; lock_loss_cnt = 0.
- All outputs are registered.
- `lock_s` is `pll_locked` after SYNC_STAGES flops; its latency is SYNC_STAGES cycles.
- Single shared counter `cnt`, width clog2 of the largest cycle parameter. It is cleared on every state change.
- States and transitions:
  - PLL_RST: pll_rst = 1. `cnt` increments each cycle; when `cnt` == PLL_RST_CYCLES-1, go to WAIT_LOCK and clear pll_rst on the same edge.
  - WAIT_LOCK: if `lock_s` = 1, go to STABLE. Else if `cnt` == LOCK_TIMEOUT_CYCLES-1, set timeout_err and go to PLL_RST.
  - STABLE: if `lock_s` = 0, go to WAIT_LOCK; no count and no error. Else if `cnt` == LOCK_STABLE_CYCLES-1, go to RUN and set sys_rst_n = 1 and ready = 1 on the same edge.
  - RUN: if `lock_s` = 0, go to PLL_RST and, on the same edge:
    - sys_rst_n = 0, ready = 0, pll_rst = 1;
    - lock_loss_cnt increments, saturating at all-ones.
- In every state other than RUN, sys_rst_n = 0 and ready = 0.
- `soft_rst_req` = 1 in any state: go to PLL_RST with the same output updates as a lock loss, but lock_loss_cnt is NOT incremented. It takes priority over all other transitions in the same cycle.
- Lock loss and `soft_rst_req` in the same RUN cycle: treated as `soft_rst_req`; no increment.
- A `soft_rst_req` arriving while already in PLL_RST restarts `cnt` from 0, which extends the pulse.
- timeout_err and lock_loss_cnt clear only via `rst_n`.
- A lock glitch shorter than SYNC_STAGES cycles may be missed. This is accepted, since the PLL de-asserts `locked` for many cycles on a real loss.
- `rst_n` asserted mid-operation: immediate return to reset values. sys_rst_n goes low asynchronously with `rst_n`.

Decomposition:
- Shared package `pll_seq_pkg`:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RUN};
  - clog2-based counter-width function.
- One sub-module, `sync_bit`: a SYNC_STAGES-deep single-bit synchroniser with async active-low reset to 0. It is reused elsewhere for other async status bits.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
1. `rst_n` released with `pll_locked` held at 1 -> pll_rst high for edges 1-4 and low after edge 4; WAIT_LOCK→STABLE at edge 5; sys_rst_n and ready go high at edge 13.
2. `pll_locked` held at 0 -> timeout_err set at edge 36, pll_rst re-asserted for 4 cycles, then WAIT_LOCK retries; sys_rst_n stays 0 throughout.
3. In STABLE, drop `pll_locked` for 3 cycles at stable count 5, then restore -> returns to WAIT_LOCK; the full 8-cycle stable window restarts; lock_loss_cnt stays 0.
4. In RUN, drop `pll_locked` -> 2 cycles later sys_rst_n = 0, ready = 0, pll_rst = 1 and lock_loss_cnt = 1; relock yields a normal re-release.
5. With LOSS_CNT_W=2, cause 5 lock losses in RUN -> lock_loss_cnt reads 1, 2, 3, 3, 3.
6. `soft_rst_req` pulsed in RUN on the same cycle `lock_s` falls -> PLL_RST with lock_loss_cnt unchanged. Then assert `rst_n` low mid-STABLE -> all outputs return to reset values immediately.
